// File: rtl/exc_flow_ctrl_pkg.sv
// Shared types and constants for exception/ERET sequencing.
// State encodings, the "no exception" code and the default handler entry PC.
package exc_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_REDIR = 2'd2,
    ST_ERET  = 2'd3
  } state_t;

  localparam logic [4:0]  EXC_NONE         = 5'd0;
  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;

  // Earliest pipeline stage with a pending exception wins.
  function automatic logic [4:0] pick_exc(input logic [4:0] f, input logic [4:0] d,
                                          input logic [4:0] e, input logic [4:0] m);
    if (f != EXC_NONE)      return f;
    else if (d != EXC_NONE) return d;
    else if (e != EXC_NONE) return e;
    else                    return m;
  endfunction

endpackage

// File: rtl/exc_flow_ctrl_int_sync.sv
// Multi-flop synchroniser: each bit of d reaches q exactly DEPTH edges later.
// Latency DEPTH cycles; no backpressure.
module int_sync_chain #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/exc_flow_ctrl.sv
// Exception/interrupt entry and ERET return sequencer between M stage, CP0 and fetch.
// Entry: FLUSH_CYCLES of flush then redirect; ERET: one exl_clr/flush cycle then redirect; redirect waits on redir_ready.
module exc_flow_ctrl
  import exc_flow_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter int          SYNC_STAGES  = 2,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  output logic [5:0]  int_sync,
  input  logic [4:0]  exc_f,
  input  logic [4:0]  exc_d,
  input  logic [4:0]  exc_e,
  input  logic [4:0]  exc_m,
  output logic [4:0]  e_code,
  input  logic        cp0_req,
  input  logic [31:0] cp0_epc,
  input  logic        eret_m,
  output logic        flush,
  output logic        exl_clr,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready,
  output logic        busy
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  flush_cnt;
  logic [31:0] pc_q;

  int_sync_chain #(.WIDTH(6), .DEPTH(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (hw_int),
    .q     (int_sync)
  );

  assign e_code = pick_exc(exc_f, exc_d, exc_e, exc_m);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Target PC is captured only when leaving RUN so it stays stable under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt <= 3'd0;
      pc_q      <= 32'd0;
    end else if (state == ST_RUN) begin
      if (cp0_req) begin
        flush_cnt <= FLUSH_LOAD;
        pc_q      <= HANDLER_ADDR;
      end else if (eret_m) begin
        pc_q      <= cp0_epc;
      end
    end else if (state == ST_FLUSH && flush_cnt != 3'd0) begin
      flush_cnt <= flush_cnt - 3'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (cp0_req)     state_nxt = ST_FLUSH;
        else if (eret_m) state_nxt = ST_ERET;
      end
      ST_FLUSH: if (flush_cnt == 3'd0) state_nxt = ST_REDIR;
      ST_REDIR: if (redir_ready)       state_nxt = ST_RUN;
      ST_ERET:  state_nxt = ST_REDIR;
      default:  state_nxt = ST_RUN;
    endcase
  end

  assign flush       = (state == ST_FLUSH) || (state == ST_ERET);
  assign exl_clr     = (state == ST_ERET);
  assign redir_valid = (state == ST_REDIR);
  assign busy        = (state != ST_RUN);
  assign redir_pc    = pc_q;

endmodule
